sail_print_stream: RTL

- Sequential successor to the combinational print/print_endline string primitives.
- Accepts whole Sail print requests (packed byte string, length, optional endline), buffers them atomically in a byte FIFO, and drains them one byte per cycle on a valid/ready byte stream.
- The output typically feeds a UART model or the simulation console sink.
- Generalised in message width, buffer depth and newline mode.

---
 rtl/sail_print_stream_if.sv | 27 ++
 rtl/sail_print_stream.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sail_print_stream_if.sv
// Request/byte-stream bundle for sail_print_stream: whole print requests in, one byte per
// beat out, plus FIFO occupancy and load status.
interface sail_print_stream_if #(
   parameter int MAX_CHARS = 16,
   parameter int DEPTH     = 64
);
   logic                               in_valid;
   logic                               in_ready;
   logic [8*MAX_CHARS-1:0]             in_data;
   logic [$clog2(MAX_CHARS+1)-1:0]     in_len;
   logic                               in_endline;
   logic                               out_valid;
   logic                               out_ready;
   logic [7:0]                         out_data;
   logic [$clog2(DEPTH+1)-1:0]         level;
   logic                               busy;

   modport slave (
      input  in_valid, in_data, in_len, in_endline, out_ready,
      output in_ready, out_valid, out_data, level, busy
   );

   modport master (
      output in_valid, in_data, in_len, in_endline, out_ready,
      input  in_ready, out_valid, out_data, level, busy
   );
endinterface

// File: rtl/sail_print_stream.sv
// Sail print stream: accepts whole print/print_endline requests, buffers them atomically in a
// byte FIFO and drains one byte per cycle. Optional line-buffered mode: SAIL_PRINT_LINE_BUFFER_EN.
module sail_print_stream_chk #(
   parameter int VW    = 7,
   parameter int DEPTH = 64
) (
   input logic          clk,
   input logic          rst_n,
   input logic          push,
   input logic [VW-1:0] level
);
   // The input reservation must make a write into a full FIFO impossible.
   a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (level == VW'(DEPTH))));
endmodule

module sail_print_stream #(
   parameter int         MAX_CHARS = 16,
   parameter int         DEPTH     = 64,
   parameter logic [7:0] NL_CHAR   = 8'h0A
) (
   input logic                clk,
   input logic                rst_n,
   sail_print_stream_if.slave bus
);
   localparam int LW      = $clog2(MAX_CHARS + 1);
   localparam int RW      = $clog2(MAX_CHARS + 2);
   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int VW      = $clog2(DEPTH + 1);
   localparam int RESERVE = MAX_CHARS + 1;
   localparam logic [VW-1:0] READY_MAX = VW'(DEPTH - RESERVE);

   if (DEPTH < MAX_CHARS + 1) begin : g_depth_check
      $error("sail_print_stream: DEPTH must be >= MAX_CHARS+1");
   end

   typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t                 state_r, state_nxt_s;
   logic [8*MAX_CHARS-1:0] data_r;
   logic [LW-1:0]          len_r, idx_r, len_clamp_s;
   logic [RW-1:0]          rem_r, first_rem_s;
   logic [7:0]             mem_r [DEPTH];
   logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
   logic [VW-1:0]          level_r, level_nxt_s;
   logic                   in_ready_r, in_ready_nxt_s;
   logic                   accept_s, load_hold_s, push_s, pop_s, out_valid_s;
   logic [7:0]             wbyte_s, rd_byte_s;

   assign accept_s    = bus.in_valid && in_ready_r;
   assign len_clamp_s = (bus.in_len > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : bus.in_len;
   assign first_rem_s = RW'(len_clamp_s) + RW'(bus.in_endline);
   assign wbyte_s     = (idx_r < len_r) ? data_r[{idx_r, 3'b000} +: 8] : NL_CHAR;
   assign rd_byte_s   = mem_r[rd_ptr_r];
   assign pop_s       = out_valid_s && bus.out_ready;

   // Next-state and load control for the request FSM.
   always_comb begin
      state_nxt_s = state_r;
      load_hold_s = 1'b0;
      push_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               load_hold_s = 1'b1;
               if (first_rem_s != '0) begin
                  state_nxt_s = LOAD;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            push_s = 1'b1;
            if (rem_r == RW'(1)) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Occupancy after this cycle's push/pop, and the registered reservation check.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + VW'(1);
         2'b01:   level_nxt_s = level_r - VW'(1);
         default: level_nxt_s = level_r;
      endcase
      // Reserve room for a maximal request so in_ready never depends on in_len.
      in_ready_nxt_s = (state_nxt_s == IDLE) && (level_nxt_s <= READY_MAX);
   end

   // FSM state, holding register, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         data_r     <= '0;
         len_r      <= '0;
         idx_r      <= '0;
         rem_r      <= '0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         level_r    <= level_nxt_s;
         in_ready_r <= in_ready_nxt_s;
         if (load_hold_s) begin
            data_r <= bus.in_data;
            len_r  <= len_clamp_s;
            idx_r  <= '0;
            rem_r  <= first_rem_s;
         end else if (push_s) begin
            idx_r  <= idx_r + LW'(1);
            rem_r  <= rem_r - RW'(1);
         end
         if (push_s) begin
            wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? '0 : wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? '0 : rd_ptr_r + PW'(1);
         end
      end
   end

   // Byte storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wbyte_s;
      end
   end

`ifdef SAIL_PRINT_LINE_BUFFER_EN
   logic [VW-1:0] lines_r;
   logic          nl_push_s, nl_pop_s;

   assign nl_push_s = push_s && (wbyte_s == NL_CHAR);
   assign nl_pop_s  = pop_s && (rd_byte_s == NL_CHAR);

   // Count of complete lines held in the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lines_r <= '0;
      end else begin
         case ({nl_push_s, nl_pop_s})
            2'b10:   lines_r <= lines_r + VW'(1);
            2'b01:   lines_r <= lines_r - VW'(1);
            default: lines_r <= lines_r;
         endcase
      end
   end

   // Hold partial lines back unless the buffer is close to full.
   assign out_valid_s = (level_r != '0) &&
                        ((lines_r != '0) || (level_r >= VW'(DEPTH - MAX_CHARS)));
`else
   assign out_valid_s = (level_r != '0);
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = (level_r != '0) ? rd_byte_s : 8'h00;
   assign bus.level     = level_r;
   assign bus.busy      = (state_r == LOAD);

   sail_print_stream_chk #(.VW(VW), .DEPTH(DEPTH)) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .level (level_r)
   );
endmodule
